// File: rtl/posit_encode_pipe.sv
// Posit encoder back end: packs sign / total exponent / fraction / sticky into an
// N-bit posit with round-to-nearest-even. Two register stages, valid/ready on both sides.
module posit_encode_pipe #(
  parameter int unsigned N              = 16,
  parameter int unsigned ES             = 1,
  parameter int unsigned TE_BITS        = 8,
  parameter int unsigned FRAC_FULL_SIZE = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic                      is_zero_i,
  input  logic                      is_nar_i,
  input  logic                      sign_i,
  input  logic [TE_BITS-1:0]        te_i,
  input  logic [FRAC_FULL_SIZE-1:0] frac_i,
  input  logic                      frac_truncated_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [N-1:0]              posit_o
);

  // Exponent field is carried as at least one bit so ES = 0 still elaborates.
  localparam int unsigned EW = (ES > 0) ? ES : 1;
  localparam int unsigned TW = TE_BITS + 1;
  // Body string: terminator, exponent, fraction, then N zero bits of headroom for the
  // regime run shifted in from the top.
  localparam int unsigned W  = N + EW + FRAC_FULL_SIZE + 1;
  localparam int unsigned FF = FRAC_FULL_SIZE;

  localparam logic signed [TW-1:0] KMax = TW'(N - 2);
  localparam logic signed [TW-1:0] KMin = -KMax;

  logic adv1, adv2;

  // Stage 1 registers
  logic              s1_valid_q, s1_valid_d;
  logic              s1_nar_q, s1_nar_d;
  logic              s1_zero_q, s1_zero_d;
  logic              s1_sign_q, s1_sign_d;
  logic              s1_sat_hi_q, s1_sat_hi_d;
  logic              s1_sat_lo_q, s1_sat_lo_d;
  logic              s1_rpos_q, s1_rpos_d;
  logic [TW-1:0]     s1_rlen_q, s1_rlen_d;
  logic [EW-1:0]     s1_e_q, s1_e_d;
  logic [FF-1:0]     s1_frac_q, s1_frac_d;
  logic              s1_trunc_q, s1_trunc_d;

  // Stage 2 registers
  logic              s2_valid_q, s2_valid_d;
  logic [N-1:0]      posit_q, posit_d;

  logic signed [TW-1:0] te_ext;
  logic signed [TW-1:0] k;

  assign adv2       = !s2_valid_q | out_ready_i;
  assign adv1       = !s1_valid_q | adv2;
  assign in_ready_o = adv1;

  // Stage 1: split te into regime k and exponent e, decide saturation and run length
  always_comb begin
    te_ext      = $signed({te_i[TE_BITS-1], te_i});
    k           = te_ext >>> ES;
    s1_valid_d  = adv1 ? in_valid_i : s1_valid_q;
    s1_nar_d    = s1_nar_q;
    s1_zero_d   = s1_zero_q;
    s1_sign_d   = s1_sign_q;
    s1_sat_hi_d = s1_sat_hi_q;
    s1_sat_lo_d = s1_sat_lo_q;
    s1_rpos_d   = s1_rpos_q;
    s1_rlen_d   = s1_rlen_q;
    s1_e_d      = s1_e_q;
    s1_frac_d   = s1_frac_q;
    s1_trunc_d  = s1_trunc_q;
    if (adv1 && in_valid_i) begin
      s1_nar_d    = is_nar_i;
      s1_zero_d   = is_zero_i;
      s1_sign_d   = sign_i;
      s1_sat_hi_d = (k >= KMax);
      s1_sat_lo_d = (k < KMin);
      s1_rpos_d   = !k[TW-1];
      // Saturated results ignore the body, so the shift is parked at zero.
      if ((k >= KMax) || (k < KMin)) begin
        s1_rlen_d = '0;
      end else if (!k[TW-1]) begin
        s1_rlen_d = k + TW'(1);
      end else begin
        s1_rlen_d = -k;
      end
      s1_e_d      = te_i[EW-1:0];
      s1_frac_d   = frac_i;
      s1_trunc_d  = frac_truncated_i;
    end
  end

  // Stage 1 state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q  <= 1'b0;
      s1_nar_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s1_rpos_q   <= 1'b0;
      s1_rlen_q   <= '0;
      s1_e_q      <= '0;
      s1_frac_q   <= '0;
      s1_trunc_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_nar_q    <= s1_nar_d;
      s1_zero_q   <= s1_zero_d;
      s1_sign_q   <= s1_sign_d;
      s1_sat_hi_q <= s1_sat_hi_d;
      s1_sat_lo_q <= s1_sat_lo_d;
      s1_rpos_q   <= s1_rpos_d;
      s1_rlen_q   <= s1_rlen_d;
      s1_e_q      <= s1_e_d;
      s1_frac_q   <= s1_frac_d;
      s1_trunc_q  <= s1_trunc_d;
    end
  end

  // Exponent+fraction field; with ES = 0 the exponent slot is dropped from the string.
  logic [EW+FF-1:0] ef;
  if (ES > 0) begin : g_exp
    assign ef = {s1_e_q, s1_frac_q};
  end else begin : g_noexp
    assign ef = {s1_frac_q, 1'b0};
  end

  logic [W-1:0]   body_init, body;
  logic [N-2:0]   u, mag;
  logic           guard, sticky, round_up;
  logic [N-1:0]   pos_mag;

  // Stage 2: build regime string, round to nearest even, saturate, apply sign and flags
  always_comb begin
    body_init = {!s1_rpos_q, ef, {N{1'b0}}};
    body      = body_init >> s1_rlen_q;
    if (s1_rpos_q) begin
      body = body | ~({W{1'b1}} >> s1_rlen_q);
    end
    u        = body[W-1 -: N-1];
    guard    = body[W-N];
    sticky   = (|body[W-N-1:0]) | s1_trunc_q;
    round_up = guard & (u[0] | sticky);
    if (&u) begin
      mag = u;
    end else begin
      mag = u + {{(N-2){1'b0}}, round_up};
    end
    if (mag == '0) begin
      mag = {{(N-2){1'b0}}, 1'b1};
    end
    if (s1_sat_hi_q) begin
      mag = {(N-1){1'b1}};
    end else if (s1_sat_lo_q) begin
      mag = {{(N-2){1'b0}}, 1'b1};
    end
    pos_mag = {1'b0, mag};

    s2_valid_d = adv2 ? s1_valid_q : s2_valid_q;
    posit_d    = posit_q;
    if (adv2 && s1_valid_q) begin
      if (s1_nar_q) begin
        posit_d = {1'b1, {(N-1){1'b0}}};
      end else if (s1_zero_q) begin
        posit_d = '0;
      end else if (s1_sign_q) begin
        posit_d = -pos_mag;
      end else begin
        posit_d = pos_mag;
      end
    end
  end

  // Stage 2 / output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q <= 1'b0;
      posit_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      posit_q    <= posit_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign posit_o     = posit_q;

endmodule

// File: tb/tb_posit_encode_pipe.sv
// Scoreboard bench for posit_encode_pipe (N=16, ES=1, TE_BITS=8, FRAC_FULL_SIZE=32).
module tb_posit_encode_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic        is_zero_i = 1'b0;
  logic        is_nar_i = 1'b0;
  logic        sign_i = 1'b0;
  logic [7:0]  te_i = '0;
  logic [31:0] frac_i = '0;
  logic        frac_truncated_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [15:0] posit_o;

  posit_encode_pipe #(
    .N(16), .ES(1), .TE_BITS(8), .FRAC_FULL_SIZE(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .is_zero_i(is_zero_i), .is_nar_i(is_nar_i), .sign_i(sign_i), .te_i(te_i),
    .frac_i(frac_i), .frac_truncated_i(frac_truncated_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .posit_o(posit_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        nar;
    logic        zero;
    logic        sign;
    logic [7:0]  te;
    logic [31:0] frac;
    logic        trunc;
    logic [15:0] exp;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: the front of the queue must be on posit_o whenever out_valid_o is high,
  // which also covers stability during stalls; pop on a transfer.
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o) begin
      if (exp_q.size() > 0) begin
        check("posit_o", posit_o, exp_q[0]);
        if (out_ready_i) exp_q.delete(0);
      end else if (out_ready_i) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %h, required no output", posit_o);
      end
    end
  end

  // Present one beat and hold it until accepted; push its expected result at acceptance.
  task automatic send(input vec_t v, input bit push);
    bit done = 1'b0;
    int waited = 0;
    is_nar_i = v.nar; is_zero_i = v.zero; sign_i = v.sign; te_i = v.te;
    frac_i = v.frac; frac_truncated_i = v.trunc; in_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        done = 1'b1;
        if (push) exp_q.push_back(v.exp);
      end
      @(posedge clk_i);
      #1;
      waited++;
      if (!done && waited > 50) begin
        n_cmp++;
        n_bad++;
        $display("FAIL accept_timeout: got in_ready_o=0, required 1 within 50 cycles");
        done = 1'b1;
      end
    end
  endtask

  task automatic idle_in();
    in_valid_i = 1'b0; is_nar_i = 1'b0; is_zero_i = 1'b0; sign_i = 1'b0;
    te_i = '0; frac_i = '0; frac_truncated_i = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      @(posedge clk_i);
      cyc++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #1;
  endtask

  function automatic vec_t mk(input logic s, input logic [7:0] te, input logic [31:0] f,
                              input logic tr, input logic [15:0] e);
    vec_t v;
    v.nar = 1'b0; v.zero = 1'b0; v.sign = s; v.te = te; v.frac = f; v.trunc = tr; v.exp = e;
    return v;
  endfunction

  vec_t vecs[$];
  vec_t tmp;

  initial begin
    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out_valid", {15'd0, out_valid_o}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready_o}, 16'd1);
    check("rst_posit", posit_o, 16'h0000);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Latency: accept at edge t, out_valid_o high after edge t+1, consumed at t+2
    is_nar_i = 1'b0; te_i = 8'd0; frac_i = '0; in_valid_i = 1'b1;
    @(negedge clk_i);
    check("lat_in_ready", {15'd0, in_ready_o}, 16'd1);
    exp_q.push_back(16'h4000);
    @(posedge clk_i);
    #1 idle_in();
    @(negedge clk_i);
    check("lat_stage1_invalid", {15'd0, out_valid_o}, 16'd0);
    @(negedge clk_i);
    check("lat_stage2_valid", {15'd0, out_valid_o}, 16'd1);
    drain();

    // Directed vectors, sent back to back
    vecs.push_back(mk(1'b0, 8'd1,    32'h0, 1'b0, 16'h5000));
    vecs.push_back(mk(1'b0, -8'sd1,  32'h0, 1'b0, 16'h3000));
    vecs.push_back(mk(1'b1, 8'd0,    32'h0, 1'b0, 16'hC000));
    vecs.push_back(mk(1'b0, 8'd3,    32'h0, 1'b0, 16'h6800));
    vecs.push_back(mk(1'b0, 8'd3,    32'hA000_0000, 1'b0, 16'h6D00));
    // Rounding at the guard bit (frac[19] for te=0)
    vecs.push_back(mk(1'b0, 8'd0,    32'h0008_0000, 1'b0, 16'h4000));
    vecs.push_back(mk(1'b0, 8'd0,    32'h0008_0000, 1'b1, 16'h4001));
    vecs.push_back(mk(1'b0, 8'd0,    32'h0018_0000, 1'b0, 16'h4002));
    vecs.push_back(mk(1'b1, 8'd0,    32'h0018_0000, 1'b0, 16'hBFFE));
    // Saturation and regime extremes
    vecs.push_back(mk(1'b0, 8'd40,   32'h0, 1'b0, 16'h7FFF));
    vecs.push_back(mk(1'b0, -8'sd40, 32'h0, 1'b0, 16'h0001));
    vecs.push_back(mk(1'b0, 8'd28,   32'h0, 1'b0, 16'h7FFF));
    vecs.push_back(mk(1'b0, -8'sd29, 32'h0, 1'b0, 16'h0001));
    // k=13, e=0: guard is the zero exponent bit, so the all-ones fraction cannot round
    vecs.push_back(mk(1'b0, 8'd26,   32'hFFFF_FFFF, 1'b0, 16'h7FFE));
    // k=13, e=1: rounds up to maxpos, never into the sign bit
    vecs.push_back(mk(1'b0, 8'd27,   32'hFFFF_FFFF, 1'b0, 16'h7FFF));
    vecs.push_back(mk(1'b1, 8'd27,   32'hFFFF_FFFF, 1'b0, 16'h8001));
    // k=-14, e=1: guard set, u odd -> rounds up from minpos
    vecs.push_back(mk(1'b0, -8'sd27, 32'h0, 1'b0, 16'h0002));
    // Flags override everything
    tmp = mk(1'b1, 8'd5, 32'h1234_5678, 1'b1, 16'h8000); tmp.nar = 1'b1;
    vecs.push_back(tmp);
    tmp = mk(1'b1, 8'd5, 32'h1234_5678, 1'b1, 16'h0000); tmp.zero = 1'b1;
    vecs.push_back(tmp);
    tmp = mk(1'b0, 8'd0, 32'h0, 1'b0, 16'h8000); tmp.nar = 1'b1; tmp.zero = 1'b1;
    vecs.push_back(tmp);
    foreach (vecs[i]) send(vecs[i], 1'b1);
    idle_in();
    drain();

    // Six-beat stream with a three-cycle downstream stall
    vecs.delete();
    vecs.push_back(mk(1'b0, 8'd0, 32'h0, 1'b0, 16'h4000));
    vecs.push_back(mk(1'b0, 8'd1, 32'h0, 1'b0, 16'h5000));
    vecs.push_back(mk(1'b0, 8'd2, 32'h0, 1'b0, 16'h6000));
    vecs.push_back(mk(1'b0, 8'd3, 32'h0, 1'b0, 16'h6800));
    vecs.push_back(mk(1'b0, 8'd4, 32'h0, 1'b0, 16'h7000));
    vecs.push_back(mk(1'b0, 8'd5, 32'h0, 1'b0, 16'h7400));
    fork
      begin
        foreach (vecs[i]) send(vecs[i], 1'b1);
        idle_in();
      end
      begin
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("stall_in_ready_low", {15'd0, in_ready_o}, 16'd0);
        check("stall_out_valid", {15'd0, out_valid_o}, 16'd1);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 out_ready_i = 1'b1;
      end
    join
    drain();
    check("stream_all_drained", 16'(exp_q.size()), 16'd0);

    // Reset with both stages occupied: in-flight beats are discarded
    out_ready_i = 1'b0;
    send(mk(1'b0, 8'd1, 32'h0, 1'b0, 16'h5000), 1'b0);
    send(mk(1'b0, 8'd2, 32'h0, 1'b0, 16'h6000), 1'b0);
    idle_in();
    @(negedge clk_i);
    check("pre_rst_full", {15'd0, in_ready_o}, 16'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check("midrst_out_valid", {15'd0, out_valid_o}, 16'd0);
    check("midrst_in_ready", {15'd0, in_ready_o}, 16'd1);
    check("midrst_posit", posit_o, 16'h0000);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) @(posedge clk_i);
    @(negedge clk_i);
    check("post_rst_idle", {15'd0, out_valid_o}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
